wave_display: RTL

Reader-side counterpart to `wave_capture`. Reads the 8-bit samples that `wave_capture` writes into the dual-bank (2×256) sample RAM, turns them into a connected waveform trace for the VGA pixel stream, and produces `wave_display_idle`, which tells `wave_capture` when it may swap banks. It sits between the sample RAM read port and the VGA colour mux.

---
 rtl/wave_display.sv | 137 +++++++++++++
 1 files changed

// File: rtl/wave_display.sv
// wave_display: reads captured samples from the dual-bank sample RAM and
// draws them as a connected trace on the VGA pixel stream. It also raises
// wave_display_idle while the raster is outside the trace rows, which tells
// the capture side when it may swap banks.
module wave_display #(
   parameter logic [10:0] X_START    = 11'd256,
   parameter logic [9:0]  Y_ROWS     = 10'd512,
   parameter logic [23:0] WAVE_COLOR = 24'hFFFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] x,
   input  logic [9:0]  y,
   input  logic        valid,
   input  logic        read_index,
   output logic [8:0]  read_address,
   input  logic [7:0]  read_value,
   output logic        valid_pixel,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic        wave_display_idle
);

   logic       in_x;
   logic       in_y;
   logic [7:0] sample_index;
   logic       bank_q;

   logic       valid_s1;
   logic       in_x_s1;
   logic       in_y_s1;
   logic [7:0] index_s1;
   logic [7:0] level_s1;

   logic [7:0] disp;
   logic [7:0] disp_hold;
   logic [7:0] prev_disp;
   logic [7:0] last_index;
   logic [7:0] prev_sel;
   logic [7:0] lo_bound;
   logic [7:0] hi_bound;
   logic       new_index;
   logic       lit;

   // Stage 0: decode the raster position and form the RAM address. The
   // address is forced to zero while reset is held so the RAM port is quiet.
   always_comb begin
      in_x         = valid && (x >= X_START) && (x <= X_START + 11'd511);
      in_y         = (y < Y_ROWS);
      sample_index = 8'((x - X_START) >> 1);
      read_address = reset ? {bank_q, sample_index} : 9'd0;
   end

   // Idle flag follows the last visible row and holds through blanking;
   // the bank only reloads on cycles where the registered idle flag is set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wave_display_idle <= 1'b1;
         bank_q            <= 1'b0;
      end else begin
         if (valid) begin
            wave_display_idle <= !in_y;
         end
         if (wave_display_idle) begin
            bank_q <= read_index;
         end
      end
   end

   // Stage 1: carry position information alongside the RAM read latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_s1 <= 1'b0;
         in_x_s1  <= 1'b0;
         in_y_s1  <= 1'b0;
         index_s1 <= 8'd0;
         level_s1 <= 8'd0;
      end else begin
         valid_s1 <= valid;
         in_x_s1  <= in_x;
         in_y_s1  <= in_y;
         index_s1 <= sample_index;
         level_s1 <= y[8:1];
      end
   end

   // Stage 1 combinational: pick the previous sample's level and decide
   // whether this pixel lies on the vertical segment joining the two samples.
   // Index 0 always refreshes the history so a row never joins to the last
   // sample of the row before, even straight after reset.
   always_comb begin
      disp      = 8'd255 - read_value;
      new_index = in_x_s1 && ((index_s1 != last_index) || (index_s1 == 8'd0));
      if (index_s1 == 8'd0) begin
         prev_sel = disp;
      end else if (index_s1 != last_index) begin
         prev_sel = disp_hold;
      end else begin
         prev_sel = prev_disp;
      end
      lo_bound = (prev_sel < disp) ? prev_sel : disp;
      hi_bound = (prev_sel < disp) ? disp : prev_sel;
      lit      = in_x_s1 && in_y_s1 && (level_s1 >= lo_bound) && (level_s1 <= hi_bound);
   end

   // Sample history: shift in a new level on the first column of each sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_disp  <= 8'd0;
         disp_hold  <= 8'd0;
         last_index <= 8'd0;
      end else if (new_index) begin
         prev_disp  <= disp_hold;
         disp_hold  <= disp;
         last_index <= index_s1;
      end
   end

   // Stage 2: registered pixel outputs, black outside the visible area.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_pixel <= 1'b0;
         r           <= 8'd0;
         g           <= 8'd0;
         b           <= 8'd0;
      end else begin
         valid_pixel <= valid_s1;
         if (valid_s1 && lit) begin
            {r, g, b} <= WAVE_COLOR;
         end else begin
            {r, g, b} <= 24'h0;
         end
      end
   end

endmodule
